// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and architectural register file of the 5-stage MIPS
//   pipeline. Selects load data or the ALU result from MEM/WB, commits it to
//   the register file, and serves the two ID-stage read ports with a
//   write-through bypass. A forwarding tap exposes the write-back value to the
//   EX-stage forwarding unit, and a free-running counter tracks commits.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   WB[1:0]         {RegWrite, MemtoReg} from MEM/WB
//   readData        load data from MEM/WB
//   ALUResult       ALU result from MEM/WB
//   writeRegister   destination register index
//   readReg1/2      ID-stage source indices (rs / rt)
//   readData1/2     combinational, bypassed read values
//   fwdWrite        WB stage commits this cycle
//   fwdRegister     destination index being committed
//   fwdData         selected write-back data
//   commitCount     number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              fwdWrite,
  output logic [ADDR_W-1:0] fwdRegister,
  output logic [DATA_W-1:0] fwdData,
  output logic [31:0]       commitCount
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic [31:0]       commit_cnt;

  // Register 0 is hardwired to zero; bypass only applies to a live commit.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] bypass
  );
    if (idx == '0)
      return '0;
    else if (hit)
      return bypass;
    else
      return stored;
  endfunction

  // Write-back select and commit qualification
  always_comb begin
    wb_data = WB[0] ? readData : ALUResult;
    commit  = WB[1] && (writeRegister != '0) && !rst;
  end

  // Read ports with write-through bypass
  always_comb begin
    readData1 = read_port(readReg1, regs[readReg1],
                          commit && (writeRegister == readReg1), wb_data);
    readData2 = read_port(readReg2, regs[readReg2],
                          commit && (writeRegister == readReg2), wb_data);
  end

  always_comb begin
    fwdWrite    = commit;
    fwdRegister = writeRegister;
    fwdData     = wb_data;
    commitCount = commit_cnt;
  end

  // Register file update; reset clears every entry and drops the pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[writeRegister] <= wb_data;
    end
  end

  // Commit counter, wraps naturally at 2**32
  always_ff @(posedge clk) begin
    if (rst)
      commit_cnt <= '0;
    else if (commit)
      commit_cnt <= commit_cnt + 32'd1;
  end

endmodule
